mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 0 (0 = no timeout), meaning the number of cycles mem_req may wait without mem_ack before the block raises err.
REQ-002 SHALL have ports: clk  in  1  the single clock.
REQ-003 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have: en  in  1  accept control_signals_in this cycle.
REQ-005 SHALL have: control_signals_in  in  alu_signals  the ALU stage output bundle.
REQ-006 SHALL have: busy  out  1  high while a memory access is in progress.
REQ-007 SHALL have: mem_req  out  1, mem_we  out  1, mem_addr  out  16, mem_wdata  out  8, mem_rdata  in  8, mem_ack  in  1 (byte-wide memory bus).
REQ-008 SHALL have: rf_we  out  2 ({high, low}), rf_dest  out  4, rf_wdata  out  16 (register write port).
REQ-009 SHALL have: pc_we  out  1 and pc_wdata  out  16 (PC write port).
REQ-010 SHALL have: done  out  1 (one-cycle retire pulse) and err  out  1 (sticky timeout flag).

Function
REQ-011 SHALL use states IDLE, ACC0, ACC1 and WB.
REQ-012 In IDLE with en high, SHALL register the bundle. With mem_read = mem_write = 0 it SHALL go to WB; otherwise it SHALL go to ACC0.
REQ-013 SHALL ignore en when not in IDLE; busy SHALL be high in ACC0 and ACC1.
REQ-014 In ACC0, SHALL drive mem_req=1 and mem_addr=mem_addr_reg. mem_we SHALL equal (mem_write != 0), and mem_wdata SHALL be data_out[7:0].
REQ-015 Request signals SHALL stay stable until mem_ack is sampled high, and mem_rdata SHALL be captured on that edge.
REQ-016 On ack in ACC0, SHALL go to ACC1 if the access is a word (bit1 = 1); otherwise it SHALL go to WB.
REQ-017 In ACC1, SHALL drive address mem_addr_reg+1, wrapping modulo 2^16 (0xFFFF -> 0x0000), and mem_wdata = data_out[15:8]. On ack it SHALL go to WB.
REQ-018 mem_req MAY stay high from ACC0 into ACC1 back-to-back; the address SHALL change on the cycle after the ACC0 ack.
REQ-019 Word data SHALL be little-endian: low byte at addr, high byte at addr+1.
REQ-020 If mem_read and mem_write are both nonzero, the block SHALL perform only the write.
REQ-021 In WB, SHALL assert done for 1 cycle and then return to IDLE; a new en SHALL be accepted in that same WB cycle.
REQ-022 In WB with no memory op: rf_we=reg_write, rf_wdata=data_out, pc_we=setPC, pc_wdata=data_out.
REQ-023 In WB after a word read: rf_wdata = pc_wdata = {byte1, byte0}, with rf_we=reg_write and pc_we=setPC.
REQ-024 In WB after a byte read: rf_wdata = {byte0, byte0}, so either half selects the byte. pc_wdata SHALL be {8'h00, byte0}.
REQ-025 In WB after a write: rf_we=0 and pc_we=0.
REQ-026 rf_we, pc_we and done SHALL be zero outside WB, and rf_dest SHALL equal reg_dest_reg.
REQ-027 Latency: a non-memory op SHALL retire 1 cycle after acceptance. A memory op SHALL retire 1 cycle after its last ack.
REQ-028 When ACK_TIMEOUT>0 and mem_req has been high ACK_TIMEOUT cycles without ack, SHALL set err, drop mem_req, and go to IDLE without done.

Reset
REQ-029 While rst is high, SHALL hold state in IDLE and all outputs at 0, including err and the registered bundle.
REQ-030 Reset mid-access SHALL drop mem_req immediately (asynchronously) and abandon the access with no retirement.

Structure
REQ-031 The alu_signals typedef and the mem_stage state enum SHALL live in the shared CPU package, used by both the ALU stage and this block.
REQ-032 SHALL be a single module with no sub-module; the timeout counter SHALL be inline and sized $clog2(ACK_TIMEOUT+1).

Verification
REQ-033 Non-memory op: en with data_out=0x1234, reg_write=2'b11, reg_dest=5 -> next cycle rf_we=11, rf_dest=5, rf_wdata=0x1234, done=1, mem_req never high.
REQ-034 Word read: addr=0x0100, memory[0x0100]=0xCD, [0x0101]=0xAB, ack after 2 cycles each -> two requests at 0x0100 then 0x0101, then rf_wdata=0xABCD.
REQ-035 Word write at wrap boundary: addr=0xFFFF, data_out=0xBEEF -> write 0xEF at 0xFFFF, then 0xBE at 0x0000, rf_we=0, done=1.
REQ-036 Byte read to PC: setPC=1, addr=0x0020, memory[0x0020]=0x7F -> pc_we=1, pc_wdata=0x007F, rf_we=0.
REQ-037 Robustness: en pulsed during ACC0 is ignored; rst asserted during ACC1 drops mem_req the same cycle; ACK_TIMEOUT=4 with no ack sets err after 4 request cycles.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared CPU types: the ALU-stage output bundle, the memory-stage state
// encoding and the write-back helpers.
package mem_stage_pkg;

    typedef struct packed {
        logic [15:0] data_out;
        logic [15:0] mem_addr;
        logic [1:0]  mem_read;
        logic [1:0]  mem_write;
        logic [1:0]  reg_write;
        logic [3:0]  reg_dest;
        logic        setPC;
    } alu_signals;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        WB   = 2'd3
    } mem_stage_state_e;

    typedef struct packed {
        logic [1:0]  rf_we;
        logic [15:0] rf_wdata;
        logic        pc_we;
        logic [15:0] pc_wdata;
    } wb_port_t;

    function automatic logic is_write(input alu_signals s);
        return (s.mem_write != 2'b00);
    endfunction

    function automatic logic has_mem_op(input alu_signals s);
        return (s.mem_read != 2'b00) || (s.mem_write != 2'b00);
    endfunction

    // A write wins over a read, so the word flag comes from the winning field.
    function automatic logic is_word(input alu_signals s);
        return is_write(s) ? s.mem_write[1] : s.mem_read[1];
    endfunction

    // Byte reads are mirrored into both halves so either rf half can pick them up.
    function automatic wb_port_t wb_result(input alu_signals s,
                                           input logic [7:0] b0,
                                           input logic [7:0] b1);
        wb_port_t r;
        r.rf_we = s.reg_write;
        r.pc_we = s.setPC;
        if (is_write(s)) begin
            r.rf_we    = 2'b00;
            r.pc_we    = 1'b0;
            r.rf_wdata = s.data_out;
            r.pc_wdata = s.data_out;
        end else if (s.mem_read[1]) begin
            r.rf_wdata = {b1, b0};
            r.pc_wdata = {b1, b0};
        end else if (s.mem_read[0]) begin
            r.rf_wdata = {b0, b0};
            r.pc_wdata = {8'h00, b0};
        end else begin
            r.rf_wdata = s.data_out;
            r.pc_wdata = s.data_out;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide memory bus between the memory stage (master) and memory (slave).
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_stage.sv
// CPU memory stage: turns an ALU bundle into zero, one or two byte accesses
// and a single-cycle register/PC write-back, with an optional ack timeout.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  alu_signals  control_signals_in,
    output logic        busy,
    mem_stage_if.master mem,
    output logic [1:0]  rf_we,
    output logic [3:0]  rf_dest,
    output logic [15:0] rf_wdata,
    output logic        pc_we,
    output logic [15:0] pc_wdata,
    output logic        done,
    output logic        err
);

    localparam int TMO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    mem_stage_state_e state_r;
    alu_signals       ctrl_r;
    logic [7:0]       byte0_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    wb_port_t         wb_r;
    logic             tmo_hit_s;
    wb_port_t         wb_idle_s;
    wb_port_t         wb_acc0_s;
    wb_port_t         wb_acc1_s;

    assign rf_dest  = ctrl_r.reg_dest;
    assign rf_we    = wb_r.rf_we;
    assign rf_wdata = wb_r.rf_wdata;
    assign pc_we    = wb_r.pc_we;
    assign pc_wdata = wb_r.pc_wdata;

    // Timeout fires on the last permitted request cycle that still sees no ack.
    always_comb begin
        tmo_hit_s = 1'b0;
        if (ACK_TIMEOUT > 0) begin
            tmo_hit_s = (int'(tmo_cnt_r) == ACK_TIMEOUT - 1);
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Candidate write-back values for each way of reaching WB.
    always_comb begin
        wb_idle_s = wb_result(control_signals_in, 8'h00, 8'h00);
        wb_acc0_s = wb_result(ctrl_r, mem.mem_rdata, 8'h00);
        wb_acc1_s = wb_result(ctrl_r, byte0_r, mem.mem_rdata);
    end

    // Stage sequencer: accept, access low/high byte, retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            ctrl_r        <= '0;
            byte0_r       <= 8'h00;
            tmo_cnt_r     <= '0;
            wb_r          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 16'h0000;
            mem.mem_wdata <= 8'h00;
        end else begin
            done       <= 1'b0;
            wb_r.rf_we <= 2'b00;
            wb_r.pc_we <= 1'b0;
            case (state_r)
                IDLE, WB: begin
                    if (en) begin
                        ctrl_r    <= control_signals_in;
                        tmo_cnt_r <= '0;
                        if (has_mem_op(control_signals_in)) begin
                            state_r       <= ACC0;
                            busy          <= 1'b1;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= is_write(control_signals_in);
                            mem.mem_addr  <= control_signals_in.mem_addr;
                            mem.mem_wdata <= control_signals_in.data_out[7:0];
                        end else begin
                            state_r <= WB;
                            done    <= 1'b1;
                            wb_r    <= wb_idle_s;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACC0: begin
                    if (mem.mem_ack) begin
                        byte0_r   <= mem.mem_rdata;
                        tmo_cnt_r <= '0;
                        if (is_word(ctrl_r)) begin
                            state_r       <= ACC1;
                            mem.mem_addr  <= ctrl_r.mem_addr + 16'd1;
                            mem.mem_wdata <= ctrl_r.data_out[15:8];
                        end else begin
                            state_r     <= WB;
                            busy        <= 1'b0;
                            mem.mem_req <= 1'b0;
                            done        <= 1'b1;
                            wb_r        <= wb_acc0_s;
                        end
                    end else if (tmo_hit_s) begin
                        state_r     <= IDLE;
                        busy        <= 1'b0;
                        mem.mem_req <= 1'b0;
                        err         <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                ACC1: begin
                    if (mem.mem_ack) begin
                        state_r     <= WB;
                        busy        <= 1'b0;
                        mem.mem_req <= 1'b0;
                        done        <= 1'b1;
                        wb_r        <= wb_acc1_s;
                    end else if (tmo_hit_s) begin
                        state_r     <= IDLE;
                        busy        <= 1'b0;
                        mem.mem_req <= 1'b0;
                        err         <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    busy        <= 1'b0;
                    mem.mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level
// model of the expected bus requests and write-back results.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk;
    logic rst;
    logic en, en_t;
    alu_signals cs_in, cs_t;
    logic busy, busy_t;
    logic [1:0] rf_we, rf_we_t;
    logic [3:0] rf_dest, rf_dest_t;
    logic [15:0] rf_wdata, rf_wdata_t, pc_wdata, pc_wdata_t;
    logic pc_we, pc_we_t, done, done_t, err, err_t;
    logic [7:0] mem_arr [0:65535];
    int checks = 0;
    int errors = 0;

    mem_stage_if bus ();
    mem_stage_if bus_t ();

    mem_stage #(.ACK_TIMEOUT(0)) dut (
        .clk(clk), .rst(rst), .en(en), .control_signals_in(cs_in), .busy(busy),
        .mem(bus), .rf_we(rf_we), .rf_dest(rf_dest), .rf_wdata(rf_wdata),
        .pc_we(pc_we), .pc_wdata(pc_wdata), .done(done), .err(err));

    mem_stage #(.ACK_TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .en(en_t), .control_signals_in(cs_t), .busy(busy_t),
        .mem(bus_t), .rf_we(rf_we_t), .rf_dest(rf_dest_t), .rf_wdata(rf_wdata_t),
        .pc_we(pc_we_t), .pc_wdata(pc_wdata_t), .done(done_t), .err(err_t));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic alu_signals rand_bundle();
        alu_signals r;
        r.data_out  = 16'($urandom);
        r.mem_addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        r.mem_read  = 2'($urandom);
        r.mem_write = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
        r.reg_write = 2'($urandom);
        r.reg_dest  = 4'($urandom);
        r.setPC     = 1'($urandom);
        return r;
    endfunction

    // Issue one bundle, play memory with the given ack delay, check bus and retire.
    task automatic run_op(input alu_signals s, input int delay, input bit poke);
        bit wr, rd, word, acked, finished;
        int exp_n, idx, wait_c;
        logic [15:0] exp_addr [2];
        logic [7:0] exp_wd [2];
        logic [7:0] b0, b1;
        logic [15:0] e_rf, e_pc;
        alu_signals junk;
        wr = (s.mem_write != 2'b00);
        rd = !wr && (s.mem_read != 2'b00);
        word = wr ? s.mem_write[1] : s.mem_read[1];
        exp_n = (wr || rd) ? (word ? 2 : 1) : 0;
        exp_addr[0] = s.mem_addr;
        exp_addr[1] = s.mem_addr + 16'd1;
        exp_wd[0] = s.data_out[7:0];
        exp_wd[1] = s.data_out[15:8];
        b0 = mem_arr[exp_addr[0]];
        b1 = mem_arr[exp_addr[1]];
        if (rd && word) begin
            e_rf = 16'(int'(b0) + 256 * int'(b1));
            e_pc = e_rf;
        end else if (rd) begin
            e_rf = 16'(int'(b0) * 257);
            e_pc = 16'(int'(b0));
        end else begin
            e_rf = s.data_out;
            e_pc = s.data_out;
        end
        @(negedge clk);
        en = 1'b1;
        cs_in = s;
        @(negedge clk);
        en = 1'b0;
        cs_in = rand_bundle();
        idx = 0; wait_c = 0; acked = 1'b0; finished = 1'b0;
        for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                en = 1'b0;
            end
            bus.mem_ack = 1'b0;
            bus.mem_rdata = 8'($urandom);
            if (acked && idx == exp_n) check_value("retire_lat", done, 1);
            acked = 1'b0;
            if (exp_n == 0 && cyc == 0) check_value("nonmem_lat", done, 1);
            if (poke && cyc == 0 && exp_n > 0) begin
                junk = rand_bundle();
                junk.mem_read = 2'b00;
                junk.mem_write = 2'b00;
                junk.reg_dest = ~s.reg_dest;
                en = 1'b1;
                cs_in = junk;
            end
            if (done) begin
                finished = 1'b1;
                check_value("req_count", idx, exp_n);
                check_value("wb_rf_we", rf_we, wr ? 2'b00 : s.reg_write);
                check_value("wb_pc_we", pc_we, wr ? 1'b0 : s.setPC);
                check_value("wb_rf_dest", rf_dest, s.reg_dest);
                check_value("wb_req_low", {bus.mem_req, busy}, 0);
                if (!wr) begin
                    check_value("wb_rf_wdata", rf_wdata, e_rf);
                    check_value("wb_pc_wdata", pc_wdata, e_pc);
                end
            end else if (bus.mem_req) begin
                if (idx >= exp_n) begin
                    check_value("extra_req", 1, 0);
                    break;
                end
                check_value("req_addr", bus.mem_addr, exp_addr[idx]);
                check_value("req_we", bus.mem_we, wr);
                if (wr) check_value("req_wdata", bus.mem_wdata, exp_wd[idx]);
                check_value("req_busy", busy, 1);
                check_value("req_quiet_we", {rf_we, pc_we}, 0);
                if (wait_c >= delay) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = mem_arr[bus.mem_addr];
                    if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
                    idx++;
                    wait_c = 0;
                    acked = 1'b1;
                end else begin
                    wait_c++;
                end
            end
        end
        if (!finished) check_value("no_retire", 0, 1);
        @(negedge clk);
        en = 1'b0;
        bus.mem_ack = 1'b0;
        check_value("done_pulse", done, 0);
    endtask

    initial begin
        alu_signals s, s2;
        int n;
        bit seen_done;
        rst = 1'b1;
        en = 1'b0; en_t = 1'b0;
        cs_in = '0; cs_t = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
        bus_t.mem_ack = 1'b0; bus_t.mem_rdata = 8'h00;
        for (int i = 0; i < 65536; i++) mem_arr[i] = 8'($urandom);
        repeat (2) @(negedge clk);
        check_value("rst_ctl", {busy, done, err, rf_we, pc_we}, 0);
        check_value("rst_bus", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
        check_value("rst_wb", {rf_dest, rf_wdata}, 0);
        check_value("rst_pc", pc_wdata, 0);
        check_value("rst_t", {busy_t, done_t, err_t, rf_we_t, pc_we_t, rf_dest_t}, 0);
        check_value("rst_t_data", {rf_wdata_t, pc_wdata_t}, 0);
        check_value("rst_t_bus", {bus_t.mem_req, bus_t.mem_we, bus_t.mem_addr, bus_t.mem_wdata}, 0);
        rst = 1'b0;

        s = '0; s.data_out = 16'h1234; s.reg_write = 2'b11; s.reg_dest = 4'd5;
        run_op(s, 0, 1'b0);
        mem_arr[16'h0100] = 8'hCD; mem_arr[16'h0101] = 8'hAB;
        s = '0; s.mem_addr = 16'h0100; s.mem_read = 2'b10; s.reg_write = 2'b11; s.reg_dest = 4'd3;
        run_op(s, 2, 1'b0);
        s = '0; s.mem_addr = 16'hFFFF; s.data_out = 16'hBEEF; s.mem_write = 2'b10; s.reg_write = 2'b11;
        run_op(s, 1, 1'b0);
        check_value("wrap_mem_lo", mem_arr[16'hFFFF], 8'hEF);
        check_value("wrap_mem_hi", mem_arr[16'h0000], 8'hBE);
        mem_arr[16'h0020] = 8'h7F;
        s = '0; s.mem_addr = 16'h0020; s.mem_read = 2'b01; s.setPC = 1'b1; s.reg_dest = 4'd9;
        run_op(s, 1, 1'b0);
        s = '0; s.mem_addr = 16'h0050; s.mem_read = 2'b01; s.reg_write = 2'b01; s.reg_dest = 4'd4;
        run_op(s, 2, 1'b1);

        // A new bundle is taken in the WB cycle of the previous one.
        s = '0; s.data_out = 16'h1111; s.reg_write = 2'b01; s.reg_dest = 4'd2;
        s2 = '0; s2.data_out = 16'h2222; s2.reg_write = 2'b10; s2.reg_dest = 4'd7; s2.setPC = 1'b1;
        @(negedge clk); en = 1'b1; cs_in = s;
        @(negedge clk); cs_in = s2;
        check_value("b2b_first", {done, rf_wdata}, {1'b1, 16'h1111});
        @(negedge clk); en = 1'b0;
        check_value("b2b_second", {done, rf_we, pc_we, rf_dest, rf_wdata}, {1'b1, 2'b10, 1'b1, 4'd7, 16'h2222});
        @(negedge clk);
        check_value("b2b_idle", done, 0);

        for (int k = 0; k < 40; k++) run_op(rand_bundle(), $urandom_range(0, 3), $urandom_range(0, 3) == 0);

        // Reset in the high-byte access abandons it at once.
        s = '0; s.mem_addr = 16'h0300; s.mem_read = 2'b10; s.reg_write = 2'b11;
        @(negedge clk); en = 1'b1; cs_in = s;
        @(negedge clk); en = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5A;
        @(negedge clk); bus.mem_ack = 1'b0;
        check_value("acc1_req", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0301});
        #2 rst = 1'b1;
        #1 check_value("rst_drop_req", {bus.mem_req, busy}, 0);
        @(negedge clk);
        check_value("rst_no_retire", {done, rf_we, pc_we}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_value("post_rst_idle", {done, bus.mem_req, busy}, 0);

        // Timeout instance never sees an ack.
        s = '0; s.mem_addr = 16'h0040; s.mem_read = 2'b01; s.reg_write = 2'b11; s.reg_dest = 4'd6;
        @(negedge clk); en_t = 1'b1; cs_t = s;
        @(negedge clk); en_t = 1'b0;
        check_value("tmo_err_early", err_t, 0);
        n = 0; seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!bus_t.mem_req) break;
            n++;
            if (done_t) seen_done = 1'b1;
            @(negedge clk);
        end
        check_value("tmo_req_cycles", n, 4);
        check_value("tmo_err", err_t, 1);
        check_value("tmo_no_done", {seen_done, done_t, busy_t, rf_we_t, pc_we_t}, 0);
        check_value("tmo_dest", rf_dest_t, 4'd6);
        repeat (3) @(negedge clk);
        check_value("tmo_err_sticky", err_t, 1);
        check_value("main_no_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
